alu_status_flags: RTL and testbench
===================================

# alu_status_flags

Status-flag register and condition evaluator that sits directly downstream of the 16-bit ALU logical/arithmetic units (TST, CMP, ADD, …). It captures the N/Z/C/V flags they produce under a per-flag write mask and evaluates 4-bit branch condition codes against them with a registered, one-cycle result. It also holds a small save/restore stack for flag context on interrupt entry and exit.

## Interface
- STACK_DEPTH, 4: number of flag-context entries (power of two, ≥2)
- PTR_W, $clog2(STACK_DEPTH)+1: width of stack_depth output
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset; synchronous, active-high
- flag_in  input  4  {N,Z,C,V} from ALU stage
- flag_we  input  1  write enable for flag register
- flag_mask  input  4  per-flag write mask {N,Z,C,V}; 1 = update that flag
- cond_req  input  1  request condition evaluation
- cond_code  input  4  condition code (encoding below)
- push  input  1  save current flags to stack
- pop  input  1  restore flags from stack
- flags_out  output  4  current {N,Z,C,V}
- cond_valid  output  1  one-cycle pulse: cond_taken is valid
- cond_taken  output  1  evaluation result
- stack_depth  output  PTR_W  entries in stack
- stack_full, stack_empty  output  1  stack status (combinational from depth)
- stack_err  output  1  sticky overflow/underflow error

## Operation
- Reset: flags_out=0, cond_valid=0, cond_taken=0, stack_depth=0, stack_empty=1, stack_full=0, stack_err=0; stack contents don't-care.
- Flag write: when flag_we, each flag bit i takes flag_in[i] if flag_mask[i], else holds. flag_mask=0 is a no-op.
- Condition codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
- Evaluation uses next-state flags: a same-cycle flag_we or pop is bypassed into the evaluation (ALU result followed immediately by branch).
- Stack states (by depth): EMPTY (0), PARTIAL, FULL (STACK_DEPTH).
  - push, not full: entry[depth] ← current (pre-write) flags; depth+1.
  - push when full: dropped, depth unchanged, stack_err←1.
  - pop, not empty: depth−1; flags ← entry[depth−1], unless flag_we same cycle (see priority).
  - pop when empty: flags unchanged (flag_we still applies), stack_err←1.
  - push and pop in same cycle: both ignored, no error.
- Priority on flag register: flag_we (masked bits) over pop; unmasked bits take the popped value when pop is valid. Pop still decrements depth.
- stack_err clears only on rst.

## Timing
- Flag write latency 1: flags_out reflects write after the posedge at which flag_we was sampled.
- cond_req sampled at edge k → cond_valid=1, cond_taken valid during cycle k+1; both held until next edge. cond_valid=0 on cycles without a request; cond_taken holds its last value.
- Back-to-back cond_req each cycle: one result per cycle, no stall.
- Push/pop: depth updates 1 cycle after request; status flags follow depth combinationally.
- rst asserted mid-operation: all state cleared at that edge; a cond_req sampled in the same cycle as rst produces no cond_valid.

## Test plan
- Reset then flag_we=1, mask=4'b1111, flag_in=4'b0100 (Z) with cond_req, code=0 (EQ), same cycle → next cycle flags_out=4'b0100, cond_valid=1, cond_taken=1.
- flags=4'b1000 (N=1,V=0); cond codes 10 (GE), 11 (LT), 13 (LE) on consecutive cycles → cond_taken 0, 1, 1; cond_valid high for 3 cycles.
- flags=4'b1111, flag_we mask=4'b0010, flag_in=4'b0000 → flags_out=4'b1101; cond code 2 (CS) → taken 0.
- Push 4 distinct values (4'b0001, 4'b0010, 4'b0100, 4'b1000); 5th push → stack_full=1, depth=4, stack_err=1; four pops → flags_out 4'b1000, 4'b0100, 4'b0010, 4'b0001, stack_empty=1.
- Pop on empty → stack_err=1, flags unchanged; push+pop same cycle at depth 2 → depth stays 2, no new error.
- pop with flag_we mask=4'b1000, flag_in=4'b1000, stacked entry 4'b0111 → flags_out=4'b1111, depth−1; rst asserted with cond_req → cond_valid=0 and all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_status_flags.sv
// Status-flag register with masked writes, registered branch-condition evaluator
// and a small LIFO for saving/restoring flag context around interrupts.
module alu_status_flags #(
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned PTR_W       = $clog2(STACK_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       flag_in_i,
    input  logic             flag_we_i,
    input  logic [3:0]       flag_mask_i,
    input  logic             cond_req_i,
    input  logic [3:0]       cond_code_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [3:0]       flags_o,
    output logic             cond_valid_o,
    output logic             cond_taken_o,
    output logic [PTR_W-1:0] stack_depth_o,
    output logic             stack_full_o,
    output logic             stack_empty_o,
    output logic             stack_err_o
);

    localparam int unsigned IdxW = PTR_W - 1;

    logic [3:0]       flags_q, flags_d;
    logic             cond_valid_q;
    logic             cond_taken_q, cond_taken_d;
    logic [PTR_W-1:0] depth_q, depth_d;
    logic             err_q, err_d;
    logic [3:0]       stack_mem [STACK_DEPTH];

    logic             full, empty;
    logic             push_ok, pop_ok;
    logic [IdxW-1:0]  wr_idx, rd_idx;
    logic [3:0]       base_flags;

    assign full   = (depth_q == PTR_W'(STACK_DEPTH));
    assign empty  = (depth_q == '0);
    assign wr_idx = depth_q[IdxW-1:0];
    assign rd_idx = IdxW'(depth_q - 1'b1);

    // Simultaneous push and pop cancel each other and raise no error.
    assign push_ok = push_i && !pop_i && !full;
    assign pop_ok  = pop_i && !push_i && !empty;

    // Next-state flags: popped context under masked ALU write; depth and sticky error.
    always_comb begin
        base_flags = pop_ok ? stack_mem[rd_idx] : flags_q;
        flags_d    = flag_we_i ? ((flag_in_i & flag_mask_i) | (base_flags & ~flag_mask_i))
                               : base_flags;
        depth_d    = depth_q;
        if (push_ok) begin
            depth_d = depth_q + 1'b1;
        end else if (pop_ok) begin
            depth_d = depth_q - 1'b1;
        end
        err_d = err_q;
        if ((push_i && !pop_i && full) || (pop_i && !push_i && empty)) begin
            err_d = 1'b1;
        end
    end

    // Condition evaluation on next-state flags so a same-cycle write or pop is bypassed.
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags_d;
        cond_taken_d = cond_taken_q;
        if (cond_req_i) begin
            unique case (cond_code_i)
                4'd0:    cond_taken_d = z;
                4'd1:    cond_taken_d = !z;
                4'd2:    cond_taken_d = c;
                4'd3:    cond_taken_d = !c;
                4'd4:    cond_taken_d = n;
                4'd5:    cond_taken_d = !n;
                4'd6:    cond_taken_d = v;
                4'd7:    cond_taken_d = !v;
                4'd8:    cond_taken_d = c && !z;
                4'd9:    cond_taken_d = !c || z;
                4'd10:   cond_taken_d = (n == v);
                4'd11:   cond_taken_d = (n != v);
                4'd12:   cond_taken_d = !z && (n == v);
                4'd13:   cond_taken_d = z || (n != v);
                4'd14:   cond_taken_d = 1'b1;
                default: cond_taken_d = 1'b0;
            endcase
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags_q      <= '0;
            cond_valid_q <= 1'b0;
            cond_taken_q <= 1'b0;
            depth_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            cond_valid_q <= cond_req_i;
            cond_taken_q <= cond_taken_d;
            depth_q      <= depth_d;
            err_q        <= err_d;
        end
    end

    // Stack storage saves pre-write flags; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok) begin
            stack_mem[wr_idx] <= flags_q;
        end
    end

    assign flags_o       = flags_q;
    assign cond_valid_o  = cond_valid_q;
    assign cond_taken_o  = cond_taken_q;
    assign stack_depth_o = depth_q;
    assign stack_full_o  = full;
    assign stack_empty_o = empty;
    assign stack_err_o   = err_q;

endmodule

// File: tb/tb_alu_status_flags.sv
// Randomized and directed bench for alu_status_flags against a behavioural model.
module tb_alu_status_flags;

    localparam int Depth = 4;
    localparam int PtrW  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      flag_in, flag_mask, cond_code;
    logic            flag_we, cond_req, push, pop;
    logic [3:0]      flags_out;
    logic            cond_valid, cond_taken;
    logic [PtrW-1:0] stack_depth;
    logic            stack_full, stack_empty, stack_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [3:0] m_flags;
    logic [3:0] m_stk[$];
    logic       m_err, m_vld, m_tkn;

    alu_status_flags #(.STACK_DEPTH(Depth), .PTR_W(PtrW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flag_in_i    (flag_in),
        .flag_we_i    (flag_we),
        .flag_mask_i  (flag_mask),
        .cond_req_i   (cond_req),
        .cond_code_i  (cond_code),
        .push_i       (push),
        .pop_i        (pop),
        .flags_o      (flags_out),
        .cond_valid_o (cond_valid),
        .cond_taken_o (cond_taken),
        .stack_depth_o(stack_depth),
        .stack_full_o (stack_full),
        .stack_empty_o(stack_empty),
        .stack_err_o  (stack_err)
    );

    always #5 clk = ~clk;

    // Codes come in complementary pairs; even code is the base condition.
    function automatic logic eval(input logic [3:0] f, input logic [3:0] code);
        logic n, z, c, v, b;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (code >> 1)
            0: b = z;
            1: b = c;
            2: b = n;
            3: b = v;
            4: b = c & ~z;
            5: b = (n == v);
            6: b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        return b ^ code[0];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("flags_out", int'(flags_out), int'(m_flags));
        check("cond_valid", int'(cond_valid), int'(m_vld));
        check("cond_taken", int'(cond_taken), int'(m_tkn));
        check("stack_depth", int'(stack_depth), m_stk.size());
        check("stack_full", int'(stack_full), int'(m_stk.size() == Depth));
        check("stack_empty", int'(stack_empty), int'(m_stk.size() == 0));
        check("stack_err", int'(stack_err), int'(m_err));
    endtask

    task automatic model_update();
        logic [3:0] base;
        if (rst) begin
            m_flags = '0; m_stk.delete(); m_err = 0; m_vld = 0; m_tkn = 0;
        end else begin
            base = m_flags;
            if (push && !pop) begin
                if (m_stk.size() == Depth) m_err = 1;
                else m_stk.push_back(m_flags);
            end else if (pop && !push) begin
                if (m_stk.size() == 0) m_err = 1;
                else base = m_stk.pop_back();
            end
            if (flag_we) base = (flag_in & flag_mask) | (base & ~flag_mask);
            m_vld = cond_req;
            if (cond_req) m_tkn = eval(base, cond_code);
            m_flags = base;
        end
    endtask

    // One cycle: drive at negedge, model at posedge, compare at next negedge.
    task automatic step(input logic r = 0, input logic we = 0, input logic [3:0] mask = 0,
                        input logic [3:0] fin = 0, input logic req = 0,
                        input logic [3:0] code = 0, input logic pu = 0, input logic po = 0);
        rst = r; flag_we = we; flag_mask = mask; flag_in = fin;
        cond_req = req; cond_code = code; push = pu; pop = po;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        m_flags = '0; m_err = 0; m_vld = 0; m_tkn = 0;
        rst = 1; flag_we = 0; flag_mask = 0; flag_in = 0;
        cond_req = 0; cond_code = 0; push = 0; pop = 0;
        @(negedge clk);

        // Reset state
        step(1);
        check("rst_flags", int'(flags_out), 0);
        check("rst_empty", int'(stack_empty), 1);

        // Write Z and evaluate EQ in the same cycle
        step(0, 1, 4'hF, 4'b0100, 1, 4'd0);
        check("eq_flags", int'(flags_out), 4'b0100);
        check("eq_valid", int'(cond_valid), 1);
        check("eq_taken", int'(cond_taken), 1);

        // N=1,V=0: GE, LT, LE back to back
        step(0, 1, 4'hF, 4'b1000);
        step(0, 0, 0, 0, 1, 4'd10);
        check("ge_taken", int'(cond_taken), 0);
        check("ge_valid", int'(cond_valid), 1);
        step(0, 0, 0, 0, 1, 4'd11);
        check("lt_taken", int'(cond_taken), 1);
        step(0, 0, 0, 0, 1, 4'd13);
        check("le_taken", int'(cond_taken), 1);
        check("le_valid", int'(cond_valid), 1);
        step();
        check("idle_valid", int'(cond_valid), 0);

        // Masked write clears only C
        step(0, 1, 4'hF, 4'hF);
        step(0, 1, 4'b0010, 4'b0000, 1, 4'd2);
        check("mask_flags", int'(flags_out), 4'b1101);
        check("cs_taken", int'(cond_taken), 0);

        // Fill the stack, overflow, then drain
        step(1);
        step(0, 1, 4'hF, 4'b0001);
        step(0, 1, 4'hF, 4'b0010, 0, 0, 1);
        step(0, 1, 4'hF, 4'b0100, 0, 0, 1);
        step(0, 1, 4'hF, 4'b1000, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        check("fill_err", int'(stack_err), 0);
        step(0, 0, 0, 0, 0, 0, 1);
        check("ovf_full", int'(stack_full), 1);
        check("ovf_depth", int'(stack_depth), 4);
        check("ovf_err", int'(stack_err), 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("pop1", int'(flags_out), 4'b1000);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("pop2", int'(flags_out), 4'b0100);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("pop3", int'(flags_out), 4'b0010);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("pop4", int'(flags_out), 4'b0001);
        check("drain_empty", int'(stack_empty), 1);

        // Underflow
        step(1);
        step(0, 1, 4'hF, 4'b0101);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("udf_err", int'(stack_err), 1);
        check("udf_flags", int'(flags_out), 4'b0101);

        // Push and pop together at depth 2
        step(1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        check("pp_depth", int'(stack_depth), 2);
        check("pp_err", int'(stack_err), 0);

        // Pop merged with masked write
        step(0, 1, 4'hF, 4'b0111);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 4'hF, 4'b0000);
        step(0, 1, 4'b1000, 4'b1000, 0, 0, 0, 1);
        check("merge_flags", int'(flags_out), 4'b1111);
        check("merge_depth", int'(stack_depth), 2);

        // Reset with a pending request
        step(1, 1, 4'hF, 4'hF, 1, 4'd14, 1);
        check("rst_valid", int'(cond_valid), 0);
        check("rst_depth", int'(stack_depth), 0);
        check("rst_flags2", int'(flags_out), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) == 0), $urandom_range(1), 4'($urandom),
                 4'($urandom), $urandom_range(1), 4'($urandom),
                 ($urandom_range(3) == 0), ($urandom_range(3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
